divider_float: RTL and testbench
================================

Name: divider_float

Overview:
- Iterative IEEE-754-style floating-point divider (result = OP1 / OP2), the inverse operation of the pipelined floating-point multiplier in the IIR datapath.
- Used for coefficient normalisation and gain correction, where throughput is low and area matters.
- Restoring division, one quotient bit per clock, with start/done handshake; exception flag is propagated like the multiplier's.

Parameters:
WIDTH, 32, total float width
WIDTH_exp, 8, exponent field width; bias = 2^(WIDTH_exp-1)-1
WIDTH_mat, 23, mantissa field width (hidden bit not stored)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, asynchronous, active-low
start  input  1  request; sampled only when busy=0
OP1  input  WIDTH  dividend, sampled with start
OP2  input  WIDTH  divisor, sampled with start
exce_in  input  1  upstream exception, sampled with start
busy  output  1  operation in progress
done  output  1  one-cycle pulse: result/exce_out valid
exce_out  output  1  exception out, valid with done, held until next done
result  output  WIDTH  quotient, held until next done

Behaviour:
- Reset (RST=0, async): state IDLE; busy=0, done=0, exce_out=0, result=0; internal registers cleared. Reset mid-operation aborts the operation with no done pulse.
- FSM states:
  - IDLE: start=1 loads sign = OP1[MSB]^OP2[MSB], exponents, mantissas with hidden bit (WIDTH_mat+1 bits), and exce_in. Then goes to DIV with busy=1.
  - DIV: runs exactly WIDTH_mat+2 cycles (25 by default), controlled by a down-counter.
  - PACK: 1 cycle.
  - DONE: done=1 for one cycle, busy=0, then returns to IDLE.
- Latency:
  - done is high in the cycle after edge WIDTH_mat+4 counted from the start-sampling edge; this is edge 27 for defaults.
  - Latency is fixed for all operands, including special cases.
  - start is ignored while busy=1 or done=1.
- Division in DIV:
  - Remainder register is WIDTH_mat+2 bits wide, initialised to M1.
  - Each cycle: if rem >= M2 then q bit = 1 and rem -= M2, else q bit = 0; then rem <<= 1. Quotient bits are shifted in MSB first.
  - The resulting q is WIDTH_mat+2 bits and represents M1/M2 in [0.5, 2).
- Normalisation in PACK:
  - If q[MSB]=1: mantissa = q[MSB-1:1], exp = e1 - e2 + bias.
  - Otherwise: mantissa = q[MSB-2:0], exp = e1 - e2 + bias - 1.
  - Rounding is truncation toward zero.
  - The exponent is computed signed with WIDTH_exp+2 bits.
- Special cases (exponent field 0 is treated as zero, so denormals are flushed):
  - OP2 zero → result = {sign, all-ones exp, 0 mantissa}, exce_out=1.
  - Else OP1 zero → result = all zeros (sign cleared), exce_out = exce_in.
  - Overflow (exp >= 2^WIDTH_exp - 1) → result = signed infinity, exce_out=1.
  - Underflow (exp <= 0) → result = all zeros, exce_out=1.
  - Otherwise exce_out = exce_in.
  - OP1 zero and OP2 zero together → divide-by-zero case wins.
- NaN/Inf inputs are not decoded; an all-ones exponent is treated as a normal value.
- Output stability: result and exce_out change only in the cycle done rises; they are held otherwise.

Test Plan:
- Reset asserted mid-DIV (cycle 10 after start) → busy, done, result and exce_out go to 0 immediately; no done pulse follows; a new start after release works normally.
- OP1=0x3FC00000 (1.5), OP2=0x3F400000 (0.75), exce_in=0 → done at edge 27; result=0x40000000 (2.0); exce_out=0.
- OP1=0x40E00000 (7.0), OP2=0x40000000 → result=0x40600000. Then OP1=0xC0E00000 (−7.0), exce_in=1 → result=0xC0600000, exce_out=1.
- OP1=0x3F800000 (1.0), OP2=0x40400000 (3.0) → result=0x3EAAAAAA (truncated); exce_out=0.
- OP1=0x40E00000, OP2=0x00000000 → result=0x7F800000, exce_out=1. OP1=0x7F000000, OP2=0x3E800000 (overflow) → result=0x7F800000, exce_out=1.
- start held high continuously with changing OP1/OP2 → only operands present in IDLE cycles are accepted; done pulses every 28 cycles; busy stays high between acceptance and done.

Source files
------------

// File: rtl/divider_float.sv
// divider_float -- iterative floating-point divider, result = OP1 / OP2.
// Restoring division producing one quotient bit per clock. Latency is fixed
// for every operand combination, including the special cases.
//
// Ports:
//   CLK      rising-edge clock
//   RST      asynchronous active-low reset (aborts an operation, no done)
//   start    request, sampled only while idle (busy=0, done=0)
//   OP1      dividend, sampled with start
//   OP2      divisor, sampled with start
//   exce_in  upstream exception flag, sampled with start
//   busy     operation in progress
//   done     one-cycle pulse, result/exce_out updated in this cycle
//   exce_out exception out, held until next done
//   result   quotient, held until next done
module divider_float #(
   parameter int WIDTH     = 32,
   parameter int WIDTH_exp = 8,
   parameter int WIDTH_mat = 23
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   input  logic [WIDTH-1:0] OP1,
   input  logic [WIDTH-1:0] OP2,
   input  logic             exce_in,
   output logic             busy,
   output logic             done,
   output logic             exce_out,
   output logic [WIDTH-1:0] result
);

   localparam int MW = WIDTH_mat;
   localparam int QW = WIDTH_mat + 2;     // remainder / quotient width
   localparam int EW = WIDTH_exp;
   localparam int XW = WIDTH_exp + 2;     // signed working exponent width
   localparam int CW = $clog2(WIDTH_mat + 3);

   localparam logic [CW-1:0]        CNT_INIT = CW'(WIDTH_mat + 2);
   localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
   localparam logic signed [XW-1:0] BIAS_X   = XW'((1 << (EW - 1)) - 1);
   localparam logic signed [XW-1:0] EMAX_X   = XW'((1 << EW) - 1);
   localparam logic signed [XW-1:0] ONE_X    = XW'(1);
   localparam logic signed [XW-1:0] ZERO_X   = '0;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DIV  = 2'd1;
   localparam logic [1:0] S_PACK = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic          sign;
   logic [EW-1:0] exp1;
   logic [EW-1:0] exp2;
   logic [MW:0]   m2;
   logic [QW-1:0] rem;
   logic [QW-1:0] quo;
   logic          exce_reg;

   // One restoring-division step.
   logic          ge;
   logic [QW-1:0] rem_sub;
   logic [QW-1:0] rem_nxt;
   logic [QW-1:0] quo_nxt;

   always_comb begin
      ge      = (rem >= {1'b0, m2});
      rem_sub = ge ? (rem - {1'b0, m2}) : rem;
      // rem_sub < m2 always, so its MSB is zero and the shift loses nothing
      rem_nxt = rem_sub << 1;
      quo_nxt = {quo[QW-2:0], ge};
   end

   // Normalisation, exponent and special-case selection for PACK.
   logic signed [XW-1:0] exp_base;
   logic signed [XW-1:0] exp_norm;
   logic [MW-1:0]        mant;
   logic [WIDTH-1:0]     pack_res;
   logic                 pack_exce;

   always_comb begin
      exp_base  = $signed({2'b00, exp1}) - $signed({2'b00, exp2}) + BIAS_X;
      // quotient MSB clear means M1 < M2: one extra left shift, exponent - 1
      exp_norm  = quo[QW-1] ? exp_base : (exp_base - ONE_X);
      mant      = quo[QW-1] ? quo[QW-2:1] : quo[QW-3:0];
      pack_res  = {sign, exp_norm[EW-1:0], mant};
      pack_exce = exce_reg;
      if (exp2 == '0) begin
         pack_res  = {sign, {EW{1'b1}}, {MW{1'b0}}};
         pack_exce = 1'b1;
      end else if (exp1 == '0) begin
         pack_res  = '0;
         pack_exce = exce_reg;
      end else if (exp_norm >= EMAX_X) begin
         pack_res  = {sign, {EW{1'b1}}, {MW{1'b0}}};
         pack_exce = 1'b1;
      end else if (exp_norm <= ZERO_X) begin
         pack_res  = '0;
         pack_exce = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state    <= S_IDLE;
         cnt      <= '0;
         sign     <= 1'b0;
         exp1     <= '0;
         exp2     <= '0;
         m2       <= '0;
         rem      <= '0;
         quo      <= '0;
         exce_reg <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         exce_out <= 1'b0;
         result   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  sign     <= OP1[WIDTH-1] ^ OP2[WIDTH-1];
                  exp1     <= OP1[WIDTH-2 -: EW];
                  exp2     <= OP2[WIDTH-2 -: EW];
                  rem      <= {1'b0, 1'b1, OP1[MW-1:0]};
                  m2       <= {1'b1, OP2[MW-1:0]};
                  quo      <= '0;
                  exce_reg <= exce_in;
                  cnt      <= CNT_INIT;
                  busy     <= 1'b1;
                  state    <= S_DIV;
               end
            end
            S_DIV: begin
               rem <= rem_nxt;
               quo <= quo_nxt;
               cnt <= cnt - CNT_ONE;
               if (cnt == CNT_ONE) begin
                  state <= S_PACK;
               end
            end
            S_PACK: begin
               result   <= pack_res;
               exce_out <= pack_exce;
               done     <= 1'b1;
               busy     <= 1'b0;
               state    <= S_DONE;
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_divider_float.sv
// tb_divider_float -- self-checking bench for divider_float (default params).
// A cycle-count reference model predicts busy/done/result/exce_out every
// cycle; directed vectors additionally pin results and latency to literals.
module tb_divider_float;

   logic        CLK;
   logic        RST;
   logic        start;
   logic [31:0] OP1;
   logic [31:0] OP2;
   logic        exce_in;
   logic        busy;
   logic        done;
   logic        exce_out;
   logic [31:0] result;

   int checks   = 0;
   int failures = 0;
   bit mon_en   = 1'b0;

   divider_float #(.WIDTH(32), .WIDTH_exp(8), .WIDTH_mat(23)) dut (
      .CLK(CLK), .RST(RST), .start(start), .OP1(OP1), .OP2(OP2),
      .exce_in(exce_in), .busy(busy), .done(done), .exce_out(exce_out),
      .result(result)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Reference quotient: {exce, result} from the arithmetic definition.
   function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic ei);
      logic        s;
      logic [7:0]  ea, eb;
      logic [63:0] ma, mb, qq;
      logic [22:0] mt;
      int          e;
      s  = a[31] ^ b[31];
      ea = a[30:23];
      eb = b[30:23];
      if (eb == 8'd0) return {1'b1, s, 8'hFF, 23'd0};
      if (ea == 8'd0) return {ei, 32'd0};
      ma = {40'd0, 1'b1, a[22:0]};
      mb = {40'd0, 1'b1, b[22:0]};
      qq = (ma << 24) / mb;
      if (qq >= 64'h100_0000) begin
         mt = qq[23:1];
         e  = int'(ea) - int'(eb) + 127;
      end else begin
         mt = qq[22:0];
         e  = int'(ea) - int'(eb) + 126;
      end
      if (e >= 255) return {1'b1, s, 8'hFF, 23'd0};
      if (e <= 0) return {1'b1, 32'd0};
      return {ei, s, e[7:0], mt};
   endfunction

   // Timing model: m_cnt = edges since acceptance, -1 when idle.
   int          m_cnt = -1;
   logic [32:0] m_pend = '0;
   logic [31:0] m_res = '0;
   logic        m_exc = 1'b0;

   always @(posedge CLK or negedge RST) begin
      if (!RST) begin
         m_cnt <= -1;
         m_res <= '0;
         m_exc <= 1'b0;
      end else if (m_cnt < 0) begin
         if (start) begin
            m_pend <= model(OP1, OP2, exce_in);
            m_cnt  <= 0;
         end
      end else if (m_cnt == 26) begin
         m_cnt <= -1;
      end else begin
         m_cnt <= m_cnt + 1;
         if (m_cnt == 25) begin
            m_res <= m_pend[31:0];
            m_exc <= m_pend[32];
         end
      end
   end

   always @(negedge CLK) begin
      if (mon_en) begin
         chk("mon_busy", 64'(busy), 64'(m_cnt >= 0 && m_cnt <= 25));
         chk("mon_done", 64'(done), 64'(m_cnt == 26));
         chk("mon_result", 64'(result), 64'(m_res));
         chk("mon_exce", 64'(exce_out), 64'(m_exc));
      end
   end

   task automatic wait_idle(input string name);
      int n = 0;
      @(negedge CLK);
      while ((busy || done) && n < 100) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 100) chk({name, "_idle_timeout"}, 64'(n), 64'd0);
   endtask

   task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic ei, input logic [31:0] exp_res, input logic exp_exc);
      int lat = 0;
      chk({name, "_model"}, 64'(model(a, b, ei)), 64'({exp_exc, exp_res}));
      wait_idle(name);
      OP1 = a; OP2 = b; exce_in = ei; start = 1'b1;
      @(posedge CLK);
      #1 start = 1'b0;
      while (lat < 60) begin
         @(posedge CLK);
         #1 lat++;
         if (done) break;
      end
      chk({name, "_latency"}, 64'(lat), 64'd26);
      chk({name, "_result"}, 64'(result), 64'(exp_res));
      chk({name, "_exce"}, 64'(exce_out), 64'(exp_exc));
   endtask

   logic [31:0] tab1 [8] = '{32'h3FC00000, 32'h40E00000, 32'h3F800000, 32'hC0E00000,
                             32'h40490FDB, 32'h7F000000, 32'h00000000, 32'h3F800000};
   logic [31:0] tab2 [8] = '{32'h3F400000, 32'h40000000, 32'h40400000, 32'h40000000,
                             32'h40000000, 32'h3E800000, 32'h3F800000, 32'h00000000};

   initial begin
      int n_done;
      int last;
      RST = 1'b0; start = 1'b0; OP1 = '0; OP2 = '0; exce_in = 1'b0;
      #7 mon_en = 1'b1;
      @(negedge CLK);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_result", 64'(result), 64'd0);
      chk("reset_exce", 64'(exce_out), 64'd0);
      RST = 1'b1;

      run_op("one_point_five", 32'h3FC00000, 32'h3F400000, 1'b0, 32'h40000000, 1'b0);
      run_op("seven_by_two",   32'h40E00000, 32'h40000000, 1'b0, 32'h40600000, 1'b0);
      run_op("neg_seven_exc",  32'hC0E00000, 32'h40000000, 1'b1, 32'hC0600000, 1'b1);
      run_op("one_third",      32'h3F800000, 32'h40400000, 1'b0, 32'h3EAAAAAA, 1'b0);
      run_op("neg_third",      32'hBF800000, 32'h40400000, 1'b0, 32'hBEAAAAAA, 1'b0);
      run_op("div_zero",       32'h40E00000, 32'h00000000, 1'b0, 32'h7F800000, 1'b1);
      run_op("zero_zero",      32'h80000000, 32'h00000000, 1'b0, 32'hFF800000, 1'b1);
      run_op("zero_num",       32'h00000000, 32'h40000000, 1'b1, 32'h00000000, 1'b1);
      run_op("denorm_flush",   32'h00400000, 32'h3F800000, 1'b0, 32'h00000000, 1'b0);
      run_op("overflow",       32'h7F000000, 32'h3E800000, 1'b0, 32'h7F800000, 1'b1);
      run_op("max_exp_ok",     32'h7F000000, 32'h3F800000, 1'b0, 32'h7F000000, 1'b0);
      run_op("exp_255",        32'h7F000000, 32'h3F000000, 1'b0, 32'h7F800000, 1'b1);
      run_op("underflow",      32'h00800000, 32'h40000000, 1'b0, 32'h00000000, 1'b1);

      // Reset in the middle of a division.
      wait_idle("mid_reset");
      OP1 = 32'h40E00000; OP2 = 32'h40000000; exce_in = 1'b1; start = 1'b1;
      @(posedge CLK);
      #1 start = 1'b0;
      repeat (10) @(posedge CLK);
      #2 RST = 1'b0;
      #1;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_done", 64'(done), 64'd0);
      chk("midrst_result", 64'(result), 64'd0);
      chk("midrst_exce", 64'(exce_out), 64'd0);
      @(negedge CLK);
      RST = 1'b1;
      n_done = 0;
      repeat (40) begin
         @(negedge CLK);
         if (done) n_done++;
      end
      chk("midrst_no_done", 64'(n_done), 64'd0);
      run_op("after_reset", 32'h3FC00000, 32'h3F400000, 1'b0, 32'h40000000, 1'b0);

      // start held high with operands changing every cycle.
      wait_idle("start_held");
      start = 1'b1;
      n_done = 0;
      last = -1;
      for (int i = 0; i < 100; i++) begin
         OP1 = tab1[i % 8];
         OP2 = tab2[(i + 3) % 8];
         exce_in = i[0];
         @(negedge CLK);
         if (done) begin
            if (last >= 0) chk("held_spacing", 64'(i - last), 64'd28);
            last = i;
            n_done++;
         end
      end
      start = 1'b0;
      chk("held_pulses", 64'(n_done >= 3), 64'd1);
      wait_idle("final");
      repeat (3) @(negedge CLK);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
